// File: rtl/axis_write_data.sv
// ---------------------------------------------------------------------------
// axis_write_data
//
// Packs a narrow DATA_WIDTH word stream into AXI_DATA_WIDTH beats and drives
// them out on the AXI write data (W) channel. One cfg transaction describes
// one stream of cfg_length words. Completed beats are buffered in a FIFO of
// 2**BUF_AWIDTH entries and presented on W with valid/ready handshaking,
// wlast on every BURST_LEN-th beat and on the final beat, and byte strobes.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   cfg_length     stream length in DATA_WIDTH words (latched on cfg_valid)
//   cfg_valid      config request, honoured only while idle
//   cfg_ready      high only while idle
//   data/valid     incoming stream word
//   ready          stream word accepted when valid & ready
//   axi_wdata      W data, lane 0 (LSBs) holds the first word of the beat
//   axi_wstrb      W byte strobes
//   axi_wlast      last beat of a burst (or of the transfer)
//   axi_wvalid     W valid
//   axi_wready     W ready
//
// Build option
//   AXIS_WRITE_STRB_EN  when defined, a partial final beat only strobes the
//                       lanes that were filled; otherwise every beat is
//                       fully strobed and the zero padding is written.
// ---------------------------------------------------------------------------
module axis_write_data #(
   parameter int BUF_AWIDTH     = 9,
   parameter int CONFIG_DWIDTH  = 32,
   parameter int WIDTH_RATIO    = 16,
   parameter int BURST_LEN      = 16,
   parameter int AXI_DATA_WIDTH = 512,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CONFIG_DWIDTH-1:0]    cfg_length,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [DATA_WIDTH-1:0]       data,
   input  logic                        valid,
   output logic                        ready,
   output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
   output logic                        axi_wlast,
   output logic                        axi_wvalid,
   input  logic                        axi_wready
);

   localparam int STRB_W     = AXI_DATA_WIDTH / 8;
   localparam int LANE_BYTES = DATA_WIDTH / 8;
   localparam int LANE_W     = $clog2(WIDTH_RATIO);
   localparam int BEAT_W     = $clog2(BURST_LEN);
   localparam int DEPTH      = 1 << BUF_AWIDTH;

   localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(WIDTH_RATIO - 1);
   localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   // Two entries of headroom: one beat may already be completing in the
   // packer while another sits in the push stage.
   localparam logic [BUF_AWIDTH:0]   AFULL_LVL = (BUF_AWIDTH + 1)'(DEPTH - 2);

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      ACTIVE = 4'b0010,
      FLUSH  = 4'b0100,
      DONE   = 4'b1000
   } state_t;

   state_t state, state_next;

   logic [CONFIG_DWIDTH-1:0]  length;
   logic [CONFIG_DWIDTH-1:0]  word_cnt;
   logic [LANE_W-1:0]         lane_cnt;
   logic [AXI_DATA_WIDTH-1:0] pack_reg;
   logic [AXI_DATA_WIDTH-1:0] beat_reg;
   logic [AXI_DATA_WIDTH-1:0] beat_next;
   logic [STRB_W-1:0]         beat_strb;
   logic [STRB_W-1:0]         strb_next;
   logic                      beat_final;
   logic                      beat_pend;

   logic [AXI_DATA_WIDTH-1:0] mem_data  [DEPTH];
   logic [STRB_W-1:0]         mem_strb  [DEPTH];
   logic                      mem_final [DEPTH];
   logic [BUF_AWIDTH-1:0]     wr_ptr;
   logic [BUF_AWIDTH-1:0]     rd_ptr;
   logic [BUF_AWIDTH:0]       count;
   logic [BEAT_W-1:0]         beat_cnt;

   logic accept, last_word, beat_done, push, pop;
   logic buf_full_a, head_valid;

   assign buf_full_a = (count >= AFULL_LVL);
   assign ready      = (state == ACTIVE) & ~buf_full_a & (word_cnt < length);
   assign accept     = valid & ready;
   assign last_word  = (word_cnt == length - CONFIG_DWIDTH'(1));
   assign beat_done  = accept & ((lane_cnt == LAST_LANE) | last_word);
   assign push       = beat_pend;

   // W outputs come straight from the FIFO head. Gating with rst drops
   // wvalid in the same cycle reset is raised, and forces the idle values
   // (zero data/strobe/last) whenever nothing is buffered.
   assign head_valid = (count != '0) & ~rst;
   assign pop        = head_valid & axi_wready;
   assign axi_wvalid = head_valid;
   assign axi_wdata  = head_valid ? mem_data[rd_ptr] : '0;
   assign axi_wstrb  = head_valid ? mem_strb[rd_ptr] : '0;
   assign axi_wlast  = head_valid & ((beat_cnt == LAST_BEAT) | mem_final[rd_ptr]);

   // Beat as it looks once the current word is dropped into its lane, plus
   // the strobes that go with it.
   always_comb begin
      beat_next = pack_reg;
      beat_next[lane_cnt*DATA_WIDTH +: DATA_WIDTH] = data;
      strb_next = '0;
`ifdef AXIS_WRITE_STRB_EN
      for (int i = 0; i < WIDTH_RATIO; i++) begin
         strb_next[i*LANE_BYTES +: LANE_BYTES] =
            (LANE_W'(i) <= lane_cnt) ? {LANE_BYTES{1'b1}} : {LANE_BYTES{1'b0}};
      end
`else
      strb_next = '1;
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic; the final beat leaving on W is what ends a transfer.
   always_comb begin
      state_next = state;
      cfg_ready  = 1'b0;
      unique case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) state_next = (cfg_length == '0) ? DONE : ACTIVE;
         end
         ACTIVE: if (accept & last_word) state_next = FLUSH;
         FLUSH:  if (pop & mem_final[rd_ptr]) state_next = DONE;
         DONE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Transfer length is captured with the accepted config request.
   always_ff @(posedge clk) begin
      if (rst)                                length <= '0;
      else if ((state == IDLE) && cfg_valid)  length <= cfg_length;
   end

   // Packer, push stage, FIFO pointers and burst beat counter. Everything
   // here is held clear while idle so each transfer starts from scratch.
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE)) begin
         word_cnt   <= '0;
         lane_cnt   <= '0;
         pack_reg   <= '0;
         beat_reg   <= '0;
         beat_strb  <= '0;
         beat_final <= 1'b0;
         beat_pend  <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         beat_cnt   <= '0;
      end else begin
         beat_pend <= beat_done;
         if (accept) begin
            word_cnt <= word_cnt + CONFIG_DWIDTH'(1);
            if (beat_done) begin
               lane_cnt   <= '0;
               pack_reg   <= '0;
               beat_reg   <= beat_next;
               beat_strb  <= strb_next;
               beat_final <= last_word;
            end else begin
               lane_cnt <= lane_cnt + LANE_W'(1);
               pack_reg <= beat_next;
            end
         end
         if (push) wr_ptr <= wr_ptr + BUF_AWIDTH'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + BUF_AWIDTH'(1);
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + (BUF_AWIDTH + 1)'(1);
            2'b01:   count <= count - (BUF_AWIDTH + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage, no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_data[wr_ptr]  <= beat_reg;
         mem_strb[wr_ptr]  <= beat_strb;
         mem_final[wr_ptr] <= beat_final;
      end
   end

endmodule

// File: tb/tb_axis_write_data.sv
// ---------------------------------------------------------------------------
// tb_axis_write_data
//
// Directed bench for axis_write_data. Uses a 16-entry beat FIFO so the
// almost-full stall can be reached with a 512-word stream. Expected beats are
// rebuilt from the stream word values (word i = base + i).
// ---------------------------------------------------------------------------
module tb_axis_write_data;

   localparam int DW = 32;
   localparam int R  = 16;
   localparam int BL = 16;
   localparam int AW = 512;
   localparam int SW = AW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   cfg_length;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [DW-1:0] data;
   logic          valid;
   logic          ready;
   logic [AW-1:0] axi_wdata;
   logic [SW-1:0] axi_wstrb;
   logic          axi_wlast;
   logic          axi_wvalid;
   logic          axi_wready;

   int checks = 0;
   int errors = 0;
   int words_sent;

   logic [AW-1:0] got_data [$];
   logic [SW-1:0] got_strb [$];
   logic          got_last [$];

   axis_write_data #(
      .BUF_AWIDTH(4), .CONFIG_DWIDTH(32), .WIDTH_RATIO(R),
      .BURST_LEN(BL), .AXI_DATA_WIDTH(AW), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_length(cfg_length), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .data(data), .valid(valid), .ready(ready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready)
   );

   always #5 clk = ~clk;

   // Record every W handshake, sampled mid-cycle.
   always @(negedge clk) begin
      if (axi_wvalid && axi_wready) begin
         got_data.push_back(axi_wdata);
         got_strb.push_back(axi_wstrb);
         got_last.push_back(axi_wlast);
      end
   end

   function automatic logic [AW-1:0] exp_data(input int base, input int len, input int j);
      logic [AW-1:0] d;
      d = '0;
      for (int l = 0; l < R; l++)
         if (j*R + l < len) d[l*DW +: DW] = 32'(base + j*R + l);
      return d;
   endfunction

   function automatic logic [SW-1:0] exp_strb(input int len, input int j);
      logic [SW-1:0] s;
      int k;
      k = len - j*R;
      if (k > R) k = R;
      s = '0;
      for (int b = 0; b < k*(DW/8); b++) s[b] = 1'b1;
`ifndef AXIS_WRITE_STRB_EN
      s = '1;
`endif
      return s;
   endfunction

   function automatic logic exp_last(input int len, input int j);
      int nb;
      nb = (len + R - 1) / R;
      return ((j % BL) == BL - 1) || (j == nb - 1);
   endfunction

   task automatic clear_log();
      got_data.delete();
      got_strb.delete();
      got_last.delete();
   endtask

   task automatic apply_cfg(input int len);
      @(posedge clk); #1;
      cfg_length = 32'(len);
      cfg_valid  = 1'b1;
      @(posedge clk); #1;
      cfg_valid  = 1'b0;
   endtask

   task automatic send_words(input int base, input int n, input int pct);
      int cyc;
      words_sent = 0;
      cyc = 0;
      while (words_sent < n && cyc < 5000) begin
         @(posedge clk); #1;
         valid = ($urandom_range(0, 99) < pct);
         data  = 32'(base + words_sent);
         @(negedge clk);
         if (valid && ready) words_sent++;
         cyc++;
      end
      @(posedge clk); #1;
      valid = 1'b0;
      checks++;
      if (words_sent != n) begin
         errors++;
         $display("[TB] FAIL stream_accept: got %0d words exp %0d", words_sent, n);
      end
   endtask

   task automatic wait_idle(input string name);
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (!cfg_ready && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!cfg_ready) begin
         errors++;
         $display("[TB] FAIL %s_idle_timeout: cfg_ready %b exp 1", name, cfg_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_valid = 1'b0; cfg_length = '0;
      valid = 1'b0; data = '0; axi_wready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 6;
      if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_cfg_ready: got %b exp 1", cfg_ready); end
      if (ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b exp 0", ready); end
      if (axi_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_wvalid: got %b exp 0", axi_wvalid); end
      if (axi_wlast !== 1'b0) begin errors++; $display("[TB] FAIL rst_wlast: got %b exp 0", axi_wlast); end
      if (axi_wdata !== '0) begin errors++; $display("[TB] FAIL rst_wdata: got %h exp 0", axi_wdata); end
      if (axi_wstrb !== '0) begin errors++; $display("[TB] FAIL rst_wstrb: got %h exp 0", axi_wstrb); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // 32 words, W always ready: two beats, latency and DONE->IDLE timing.
   task automatic test_basic();
      localparam int BASE = 32'h1000;
      clear_log();
      axi_wready = 1'b1;
      apply_cfg(32);
      send_words(BASE, 32, 100);
      @(negedge clk);
      checks++;
      if (axi_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL t1_latency_early: wvalid %b exp 0", axi_wvalid); end
      @(negedge clk);
      checks += 2;
      if (axi_wvalid !== 1'b1 || axi_wlast !== 1'b1) begin
         errors++;
         $display("[TB] FAIL t1_latency: wvalid %b wlast %b exp 1 1", axi_wvalid, axi_wlast);
      end
      if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_flush_cfg_ready: got %b exp 0", cfg_ready); end
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_done_cfg_ready: got %b exp 0", cfg_ready); end
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL t1_idle_cfg_ready: got %b exp 1", cfg_ready); end
      checks++;
      if (got_data.size() != 2) begin errors++; $display("[TB] FAIL t1_beats: got %0d exp 2", got_data.size()); end
      for (int j = 0; j < got_data.size() && j < 2; j++) begin
         checks += 2;
         if (got_data[j] !== exp_data(BASE, 32, j)) begin
            errors++; $display("[TB] FAIL t1_data%0d: got %h exp %h", j, got_data[j], exp_data(BASE, 32, j));
         end
         if ({got_strb[j], got_last[j]} !== {exp_strb(32, j), exp_last(32, j)}) begin
            errors++; $display("[TB] FAIL t1_strb_last%0d: got %h/%b exp %h/%b", j, got_strb[j], got_last[j], exp_strb(32, j), exp_last(32, j));
         end
      end
   endtask

   // 20 words: second beat partial with zero padding in lanes 4..15.
   task automatic test_partial();
      localparam int BASE = 32'h2000;
      clear_log();
      axi_wready = 1'b1;
      apply_cfg(20);
      send_words(BASE, 20, 100);
      wait_idle("t2");
      checks++;
      if (got_data.size() != 2) begin errors++; $display("[TB] FAIL t2_beats: got %0d exp 2", got_data.size()); end
      for (int j = 0; j < got_data.size() && j < 2; j++) begin
         checks += 2;
         if (got_data[j] !== exp_data(BASE, 20, j)) begin
            errors++; $display("[TB] FAIL t2_data%0d: got %h exp %h", j, got_data[j], exp_data(BASE, 20, j));
         end
         if ({got_strb[j], got_last[j]} !== {exp_strb(20, j), exp_last(20, j)}) begin
            errors++; $display("[TB] FAIL t2_strb_last%0d: got %h/%b exp %h/%b", j, got_strb[j], got_last[j], exp_strb(20, j), exp_last(20, j));
         end
      end
   endtask

   // 512 words with W stalled for 1000 cycles: FIFO fills, stream stalls,
   // head beat holds steady, then all 32 beats drain.
   task automatic test_backpressure();
      localparam int BASE = 32'h3000;
      clear_log();
      axi_wready = 1'b0;
      apply_cfg(512);
      fork
         send_words(BASE, 512, 100);
         begin
            logic [AW-1:0] held;
            logic [SW-1:0] held_strb;
            logic          held_last;
            bit            have;
            int            unstable;
            have = 0; unstable = 0; held = '0; held_strb = '0; held_last = 1'b0;
            repeat (1000) begin
               @(negedge clk);
               if (axi_wvalid) begin
                  if (!have) begin
                     held = axi_wdata; held_strb = axi_wstrb; held_last = axi_wlast; have = 1;
                  end else if (axi_wdata !== held || axi_wstrb !== held_strb || axi_wlast !== held_last) begin
                     unstable++;
                  end
               end else if (have) begin
                  unstable++;
               end
            end
            checks += 4;
            if (held !== exp_data(BASE, 512, 0)) begin
               errors++; $display("[TB] FAIL t3_head: got %h exp %h", held, exp_data(BASE, 512, 0));
            end
            if (unstable != 0) begin errors++; $display("[TB] FAIL t3_stable: got %0d changes exp 0", unstable); end
            if (ready !== 1'b0) begin errors++; $display("[TB] FAIL t3_ready_stall: got %b exp 0", ready); end
            if (words_sent != 225) begin errors++; $display("[TB] FAIL t3_words_at_stall: got %0d exp 225", words_sent); end
            @(posedge clk); #1;
            axi_wready = 1'b1;
         end
      join
      wait_idle("t3");
      checks++;
      if (got_data.size() != 32) begin errors++; $display("[TB] FAIL t3_beats: got %0d exp 32", got_data.size()); end
      for (int j = 0; j < got_data.size() && j < 32; j++) begin
         checks += 2;
         if (got_data[j] !== exp_data(BASE, 512, j)) begin
            errors++; $display("[TB] FAIL t3_data%0d: got %h exp %h", j, got_data[j], exp_data(BASE, 512, j));
         end
         if (got_last[j] !== exp_last(512, j)) begin
            errors++; $display("[TB] FAIL t3_last%0d: got %b exp %b", j, got_last[j], exp_last(512, j));
         end
      end
   endtask

   // Zero length: IDLE -> DONE -> IDLE with no stream or W activity.
   task automatic test_zero_length();
      bit seen;
      seen = 0;
      axi_wready = 1'b1;
      @(posedge clk); #1;
      cfg_length = '0;
      cfg_valid  = 1'b1;
      @(posedge clk); #1;
      cfg_valid  = 1'b0;
      @(negedge clk);
      seen |= ready | axi_wvalid;
      checks++;
      if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_done: cfg_ready %b exp 0", cfg_ready); end
      @(negedge clk);
      seen |= ready | axi_wvalid;
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL t4_idle: cfg_ready %b exp 1", cfg_ready); end
      repeat (4) begin
         @(negedge clk);
         seen |= ready | axi_wvalid;
      end
      checks++;
      if (seen) begin errors++; $display("[TB] FAIL t4_quiet: ready/wvalid seen %b exp 0", seen); end
   endtask

   // 100 words with random stream valid and random W ready, plus a stray
   // config request mid-transfer that must be ignored.
   task automatic test_random();
      localparam int BASE = 32'h4000;
      clear_log();
      apply_cfg(100);
      fork
         send_words(BASE, 100, 60);
         begin
            repeat (400) begin
               @(posedge clk); #1;
               axi_wready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            axi_wready = 1'b1;
         end
         begin
            repeat (20) @(posedge clk);
            #1;
            cfg_length = 32'd3;
            cfg_valid  = 1'b1;
            @(posedge clk); #1;
            cfg_valid  = 1'b0;
         end
      join
      wait_idle("t5");
      checks++;
      if (got_data.size() != 7) begin errors++; $display("[TB] FAIL t5_beats: got %0d exp 7", got_data.size()); end
      for (int j = 0; j < got_data.size() && j < 7; j++) begin
         checks += 2;
         if (got_data[j] !== exp_data(BASE, 100, j)) begin
            errors++; $display("[TB] FAIL t5_data%0d: got %h exp %h", j, got_data[j], exp_data(BASE, 100, j));
         end
         if ({got_strb[j], got_last[j]} !== {exp_strb(100, j), exp_last(100, j)}) begin
            errors++; $display("[TB] FAIL t5_strb_last%0d: got %h/%b exp %h/%b", j, got_strb[j], got_last[j], exp_strb(100, j), exp_last(100, j));
         end
      end
   endtask

   // Reset while a beat is waiting on W, then a clean 16-word transfer.
   task automatic test_reset_mid();
      localparam int BASE = 32'h5000;
      axi_wready = 1'b0;
      apply_cfg(100);
      send_words(BASE, 20, 100);
      checks++;
      if (axi_wvalid !== 1'b1) begin errors++; $display("[TB] FAIL t6_pre_wvalid: got %b exp 1", axi_wvalid); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (axi_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL t6_drop_wvalid: got %b exp 0", axi_wvalid); end
      @(negedge clk);
      checks += 2;
      if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL t6_idle: cfg_ready %b exp 1", cfg_ready); end
      if (axi_wvalid !== 1'b0 || ready !== 1'b0) begin
         errors++; $display("[TB] FAIL t6_quiet: wvalid %b ready %b exp 0 0", axi_wvalid, ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      axi_wready = 1'b1;
      clear_log();
      apply_cfg(16);
      send_words(BASE + 100, 16, 100);
      wait_idle("t6");
      checks++;
      if (got_data.size() != 1) begin errors++; $display("[TB] FAIL t6_beats: got %0d exp 1", got_data.size()); end
      if (got_data.size() >= 1) begin
         checks += 2;
         if (got_data[0] !== exp_data(BASE + 100, 16, 0)) begin
            errors++; $display("[TB] FAIL t6_data: got %h exp %h", got_data[0], exp_data(BASE + 100, 16, 0));
         end
         if ({got_strb[0], got_last[0]} !== {exp_strb(16, 0), 1'b1}) begin
            errors++; $display("[TB] FAIL t6_strb_last: got %h/%b exp %h/1", got_strb[0], got_last[0], exp_strb(16, 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_backpressure();
      test_zero_length();
      test_random();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
